// File: rtl/rx_symbol_aligner.sv
// K28.5 comma aligner: searches all 10 bit offsets of the unaligned word stream and emits aligned symbols.
// Optional `ALIGN_LOSS_CNT_EN adds a saturating Loss_Count of LOCKED->UNLOCKED transitions.
module rx_symbol_aligner #(
    parameter logic [9:0]  COMMA_NEG    = 10'b00_1111_1010,
    parameter logic [9:0]  COMMA_POS    = 10'b11_0000_0101,
    parameter int unsigned LOCK_COUNT   = 3,
    parameter int unsigned MISALIGN_MAX = 4
) (
    input  logic       Recovered_Bit_Clk,
    input  logic       Rst_n,
    input  logic [9:0] Data_in,
    input  logic       Data_in_valid,
    output logic [9:0] Data_out,
    output logic       Data_out_valid,
    output logic       Comma_det,
    output logic       Locked,
`ifdef ALIGN_LOSS_CNT_EN
    output logic [7:0] Loss_Count,
`endif
    output logic [3:0] Offset
);

    localparam logic [3:0] LOCK_CNT_C = 4'(LOCK_COUNT);
    localparam logic [3:0] MIS_MAX_C  = 4'(MISALIGN_MAX);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_CHECK    = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    function automatic logic is_comma(input logic [9:0] sym);
        return (sym == COMMA_NEG) || (sym == COMMA_POS);
    endfunction

    state_t      state_r, state_nxt_s;
    logic [9:0]  prev_r;
    logic [3:0]  offset_r, offset_nxt_s;
    logic [3:0]  good_cnt_r, good_nxt_s, good_inc_s;
    logic [3:0]  bad_cnt_r, bad_nxt_s, bad_inc_s;
    logic [19:0] window_s;
    logic [9:0]  match_s;
    logic [3:0]  first_hit_s;
    logic        hit_at_off_s;
    logic [3:0]  sel_off_s;
    logic [9:0]  data_sel_s;
    logic        loss_evt_s;
    logic [9:0]  data_out_r;
    logic        data_out_valid_r;
    logic        comma_det_r;
    logic        locked_r;

    // Candidate search over the 20-bit window: match vector, lowest hit, hit at latched offset
    always_comb begin
        window_s     = {Data_in, prev_r};
        match_s      = 10'd0;
        first_hit_s  = 4'd0;
        hit_at_off_s = 1'b0;
        for (int k = 0; k < 10; k++) begin
            match_s[k] = is_comma(window_s[k +: 10]);
        end
        for (int k = 9; k >= 0; k--) begin
            if (match_s[k]) begin
                first_hit_s = 4'(k);
            end else begin
                first_hit_s = first_hit_s;
            end
        end
        for (int k = 0; k < 10; k++) begin
            if (offset_r == 4'(k)) begin
                hit_at_off_s = match_s[k];
            end else begin
                hit_at_off_s = hit_at_off_s;
            end
        end
        good_inc_s = (good_cnt_r == 4'hF) ? 4'hF : good_cnt_r + 4'd1;
        bad_inc_s  = (bad_cnt_r == 4'hF) ? 4'hF : bad_cnt_r + 4'd1;
    end

    // Alignment FSM next-state; advances only on a valid strobe
    always_comb begin
        state_nxt_s  = state_r;
        offset_nxt_s = offset_r;
        good_nxt_s   = good_cnt_r;
        bad_nxt_s    = bad_cnt_r;
        sel_off_s    = offset_r;
        loss_evt_s   = 1'b0;
        if (Data_in_valid) begin
            case (state_r)
                ST_UNLOCKED: begin
                    if (|match_s) begin
                        offset_nxt_s = first_hit_s;
                        sel_off_s    = first_hit_s;
                        bad_nxt_s    = 4'd0;
                        if (LOCK_CNT_C == 4'd1) begin
                            state_nxt_s = ST_LOCKED;
                            good_nxt_s  = 4'd0;
                        end else begin
                            state_nxt_s = ST_CHECK;
                            good_nxt_s  = 4'd1;
                        end
                    end else begin
                        state_nxt_s = ST_UNLOCKED;
                    end
                end
                ST_CHECK: begin
                    if (hit_at_off_s) begin
                        if (good_inc_s >= LOCK_CNT_C) begin
                            state_nxt_s = ST_LOCKED;
                            good_nxt_s  = 4'd0;
                            bad_nxt_s   = 4'd0;
                        end else begin
                            good_nxt_s = good_inc_s;
                        end
                    end else if (|match_s) begin
                        offset_nxt_s = first_hit_s;
                        sel_off_s    = first_hit_s;
                        good_nxt_s   = 4'd1;
                    end else begin
                        state_nxt_s = ST_CHECK;
                    end
                end
                ST_LOCKED: begin
                    if (hit_at_off_s) begin
                        bad_nxt_s = 4'd0;
                    end else if (|match_s) begin
                        if (bad_inc_s >= MIS_MAX_C) begin
                            // Offset is kept until the next relatch in UNLOCKED
                            state_nxt_s = ST_UNLOCKED;
                            good_nxt_s  = 4'd0;
                            bad_nxt_s   = 4'd0;
                            loss_evt_s  = 1'b1;
                        end else begin
                            bad_nxt_s = bad_inc_s;
                        end
                    end else begin
                        state_nxt_s = ST_LOCKED;
                    end
                end
                default: begin
                    state_nxt_s = ST_UNLOCKED;
                    good_nxt_s  = 4'd0;
                    bad_nxt_s   = 4'd0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Symbol extraction at the offset in force for this strobe
    always_comb begin
        data_sel_s = window_s[9:0];
        for (int k = 0; k < 10; k++) begin
            if (sel_off_s == 4'(k)) begin
                data_sel_s = window_s[k +: 10];
            end else begin
                data_sel_s = data_sel_s;
            end
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge Recovered_Bit_Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r          <= ST_UNLOCKED;
            prev_r           <= 10'd0;
            offset_r         <= 4'd0;
            good_cnt_r       <= 4'd0;
            bad_cnt_r        <= 4'd0;
            data_out_r       <= 10'd0;
            data_out_valid_r <= 1'b0;
            comma_det_r      <= 1'b0;
            locked_r         <= 1'b0;
        end else begin
            state_r          <= state_nxt_s;
            offset_r         <= offset_nxt_s;
            good_cnt_r       <= good_nxt_s;
            bad_cnt_r        <= bad_nxt_s;
            locked_r         <= (state_nxt_s == ST_LOCKED);
            data_out_valid_r <= Data_in_valid && (state_r != ST_UNLOCKED);
            comma_det_r      <= Data_in_valid && (state_r != ST_UNLOCKED) && is_comma(data_sel_s);
            if (Data_in_valid) begin
                prev_r     <= Data_in;
                data_out_r <= data_sel_s;
            end
        end
    end

`ifdef ALIGN_LOSS_CNT_EN
    logic [7:0] loss_cnt_r;

    // Saturating count of lock losses
    always_ff @(posedge Recovered_Bit_Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            loss_cnt_r <= 8'd0;
        end else if (loss_evt_s && (loss_cnt_r != 8'hFF)) begin
            loss_cnt_r <= loss_cnt_r + 8'd1;
        end
    end

    assign Loss_Count = loss_cnt_r;
`endif

    assign Data_out       = data_out_r;
    assign Data_out_valid = data_out_valid_r;
    assign Comma_det      = comma_det_r;
    assign Locked         = locked_r;
    assign Offset         = offset_r;

endmodule
